mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: address width of all address ports.
REQ-002 Parameter STARVE_LIMIT, default 4: maximum consecutive data grants while a fetch request is pending.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 if_req  input  1  fetch request; held high with if_addr stable until if_valid or if_flush.
REQ-006 if_addr  input  ADDR_WIDTH  fetch address (PC).
REQ-007 if_flush  input  1  one-cycle pulse; cancels any pending or in-flight fetch.
REQ-008 if_rdata  output  32  fetched instruction; meaningful only while if_valid is high.
REQ-009 if_valid  output  1  one-cycle pulse; fetch complete.
REQ-010 d_req  input  1  data request; held high with d_we, d_addr and d_wdata stable until d_valid.
REQ-011 d_we  input  1  1 = store, 0 = load.
REQ-012 d_addr  input  ADDR_WIDTH  data address.
REQ-013 d_wdata  input  32  store data.
REQ-014 d_rdata  output  32  load data; meaningful only while d_valid is high.
REQ-015 d_valid  output  1  one-cycle pulse; load or store complete.
REQ-016 mem_req  output  1  shared memory request; held high until mem_ack.
REQ-017 mem_we, mem_addr, mem_wdata  outputs  1/ADDR_WIDTH/32  registered copy of the granted request.
REQ-018 mem_rdata  input  32  memory read data; valid in the cycle mem_ack is high.
REQ-019 mem_ack  input  1  memory completion; may assert in the same cycle mem_req first rises, or any cycle after.

Function
REQ-020 FSM states: IDLE, BUSY_IF, BUSY_D. At most one memory transaction is outstanding.
REQ-021 In IDLE, when a request is present: register the grant, the state and the mem_* outputs; mem_req rises the next cycle.
REQ-022 Priority: data over fetch, unless starve_cnt == STARVE_LIMIT and if_req is high; then fetch is granted.
REQ-023 starve_cnt (saturating) increments on each data grant made while if_req is high, and clears on every fetch grant.
REQ-024 BUSY_x with mem_ack high: mem_req drops next cycle, the state returns to IDLE, and the owner's valid pulses next cycle with the registered mem_rdata.
REQ-025 Minimum latency: request in cycle 0, mem_req in cycle 1, ack in cycle 1, valid in cycle 2, next grant in cycle 2.
REQ-026 mem_addr, mem_we and mem_wdata stay constant while mem_req is high.
REQ-027 if_flush in IDLE or same cycle as an IDLE fetch request: no fetch granted that cycle.
REQ-028 if_flush while BUSY_IF: the transaction completes to memory, but the response is discarded and if_valid is not pulsed.
REQ-029 if_flush and mem_ack in the same cycle: the response is discarded.
REQ-030 if_valid and d_valid are never high in the same cycle.
REQ-031 if_rdata and d_rdata hold their last value when their valid is low.
REQ-032 A store raises d_valid with d_rdata unchanged.

Reset
REQ-033 rst_n low asynchronously forces: state IDLE; mem_req, if_valid and d_valid 0; starve_cnt 0; all data and address outputs 0.
REQ-034 Reset mid-transaction abandons it; a mem_ack arriving after reset release while in IDLE is ignored.

Structure
REQ-035 The state enum (IDLE/BUSY_IF/BUSY_D) and the STARVE_LIMIT default live in the shared types header.
REQ-036 The block is a single flat module; no sub-module is needed.

Verification
REQ-037 d_req=1, d_we=0, d_addr=0x100, memory acks in the same cycle with 0xDEADBEEF -> d_valid pulses in cycle 2 with d_rdata 0xDEADBEEF; mem_req high in cycle 1 only.
REQ-038 if_req and d_req both held high continuously, STARVE_LIMIT=4 -> grant order D,D,D,D,IF,D,D,D,D,IF.
REQ-039 Fetch to 0x40 granted, mem_ack delayed 3 cycles, if_flush pulsed in the 2nd busy cycle -> no if_valid; the state returns to IDLE after the ack.
REQ-040 Store d_addr=0x200, d_wdata=0x12345678 -> mem_we=1, mem_addr=0x200, mem_wdata=0x12345678 held until ack; d_valid pulses once.
REQ-041 rst_n asserted while BUSY_D -> mem_req=0 immediately; a stray mem_ack after release produces no valid pulse.
REQ-042 Random traffic -> if_valid and d_valid are never high together, and every valid matches exactly one grant.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the instruction/data memory arbiter.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY_IF = 2'd1,
      BUSY_D  = 2'd2
   } arb_state_e;

   localparam int STARVE_LIMIT_DEF = 4;

   function automatic int starve_w(input int limit);
      return (limit < 1) ? 1 : $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto one shared memory port,
// data first with a bounded starvation window for fetch.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH   = 32,
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  if_req,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   input  logic                  if_flush,
   output logic [31:0]           if_rdata,
   output logic                  if_valid,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [31:0]           d_wdata,
   output logic [31:0]           d_rdata,
   output logic                  d_valid,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   input  logic [31:0]           mem_rdata,
   input  logic                  mem_ack
);

   localparam int SW = starve_w(STARVE_LIMIT);
   localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);

   arb_state_e    state;
   logic [SW-1:0] starve_cnt;
   logic          if_drop;

   logic fetch_ok;
   logic starved;
   logic grant_d;
   logic grant_if;

   // A flush in the request cycle blocks the fetch, so data may go instead.
   assign fetch_ok = if_req & ~if_flush;
   assign starved  = (starve_cnt == LIM) & if_req;
   assign grant_d  = d_req & ~(starved & fetch_ok);
   assign grant_if = fetch_ok & ~grant_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         starve_cnt <= '0;
         if_drop    <= 1'b0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         if_valid   <= 1'b0;
         if_rdata   <= '0;
         d_valid    <= 1'b0;
         d_rdata    <= '0;
      end else begin
         if_valid <= 1'b0;
         d_valid  <= 1'b0;
         unique case (state)
            IDLE: begin
               unique case (1'b1)
                  grant_d: begin
                     state     <= BUSY_D;
                     mem_req   <= 1'b1;
                     mem_we    <= d_we;
                     mem_addr  <= d_addr;
                     mem_wdata <= d_wdata;
                     if (if_req && starve_cnt != LIM)
                        starve_cnt <= starve_cnt + 1'b1;
                  end
                  grant_if: begin
                     state      <= BUSY_IF;
                     mem_req    <= 1'b1;
                     mem_we     <= 1'b0;
                     mem_addr   <= if_addr;
                     mem_wdata  <= '0;
                     starve_cnt <= '0;
                     if_drop    <= 1'b0;
                  end
                  default: ;
               endcase
            end
            BUSY_IF: begin
               if (mem_ack) begin
                  state   <= IDLE;
                  mem_req <= 1'b0;
                  // A flush seen at any point of the fetch kills its response.
                  if (!if_drop && !if_flush) begin
                     if_valid <= 1'b1;
                     if_rdata <= mem_rdata;
                  end
               end else if (if_flush) begin
                  if_drop <= 1'b1;
               end
            end
            BUSY_D: begin
               if (mem_ack) begin
                  state   <= IDLE;
                  mem_req <= 1'b0;
                  d_valid <= 1'b1;
                  if (!mem_we)
                     d_rdata <= mem_rdata;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and random checks of mem_arbiter against a
// transaction-level memory and requester model.
module tb_mem_arbiter;

   localparam int AW  = 32;
   localparam int LIM = 4;

   logic          clk;
   logic          rst_n;
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic          if_flush;
   logic [31:0]   if_rdata;
   logic          if_valid;
   logic          d_req;
   logic          d_we;
   logic [AW-1:0] d_addr;
   logic [31:0]   d_wdata;
   logic [31:0]   d_rdata;
   logic          d_valid;
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [31:0]   mem_rdata;
   logic          mem_ack;

   mem_arbiter #(
      .ADDR_WIDTH  (AW),
      .STARVE_LIMIT(LIM)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .if_req   (if_req),
      .if_addr  (if_addr),
      .if_flush (if_flush),
      .if_rdata (if_rdata),
      .if_valid (if_valid),
      .d_req    (d_req),
      .d_we     (d_we),
      .d_addr   (d_addr),
      .d_wdata  (d_wdata),
      .d_rdata  (d_rdata),
      .d_valid  (d_valid),
      .mem_req  (mem_req),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .mem_ack  (mem_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vec;
   int miss;
   int wait_cnt;
   int ack_delay;
   bit mem_auto;
   bit rand_delay;

   logic [31:0] mem_arr [bit [31:0]];
   logic [31:0] gold    [bit [31:0]];

   int          ng, sc, guard, seen, nv;
   int          d_age, if_age;
   bit          prev_req, exp_if;
   bit          d_pend, if_pend;
   logic [31:0] exp_drd, exp_ird;

   function automatic logic [31:0] dflt(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h5A5AC3C3;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vec++;
      assert (obs === exp) else begin
         miss++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock; the memory model answers after ack_delay busy cycles.
   task automatic tick();
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (!mem_req) begin
         wait_cnt = 0;
         if (rand_delay) ack_delay = $urandom_range(0, 3);
      end else if (mem_auto) begin
         if (wait_cnt == ack_delay) begin
            mem_ack = 1'b1;
            if (mem_we) begin
               mem_arr[mem_addr] = mem_wdata;
               mem_rdata = $urandom;
            end else begin
               mem_rdata = mem_arr.exists(mem_addr) ?
                           mem_arr[mem_addr] : dflt(mem_addr);
            end
         end
         wait_cnt++;
      end
   endtask

   initial begin
      vec = 0; miss = 0; wait_cnt = 0; ack_delay = 0;
      mem_auto = 1'b1; rand_delay = 1'b0;
      rst_n = 1'b0; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
      d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
      mem_rdata = '0; mem_ack = 1'b0;
      d_pend = 1'b0; if_pend = 1'b0; d_age = 0; if_age = 0;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_mem_req",   32'(mem_req),  32'd0);
      chk("rst_mem_we",    32'(mem_we),   32'd0);
      chk("rst_mem_addr",  mem_addr,      32'd0);
      chk("rst_mem_wdata", mem_wdata,     32'd0);
      chk("rst_if_valid",  32'(if_valid), 32'd0);
      chk("rst_d_valid",   32'(d_valid),  32'd0);
      chk("rst_if_rdata",  if_rdata,      32'd0);
      chk("rst_d_rdata",   d_rdata,       32'd0);
      #3 rst_n = 1'b1;
      tick();

      // minimum-latency load
      mem_arr[32'h100] = 32'hDEADBEEF;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
      tick();
      chk("ld_c1_mem_req", 32'(mem_req), 32'd1);
      chk("ld_c1_addr",    mem_addr,     32'h100);
      chk("ld_c1_dvalid",  32'(d_valid), 32'd0);
      tick();
      chk("ld_c2_dvalid",  32'(d_valid), 32'd1);
      chk("ld_c2_rdata",   d_rdata,      32'hDEADBEEF);
      chk("ld_c2_mem_req", 32'(mem_req), 32'd0);
      d_req = 1'b0;
      tick();
      chk("ld_c3_dvalid",  32'(d_valid), 32'd0);
      chk("ld_c3_mem_req", 32'(mem_req), 32'd0);
      chk("ld_c3_hold",    d_rdata,      32'hDEADBEEF);

      // both ports saturated: fetch wins every LIM+1 grants
      if_addr = 32'h40; d_addr = 32'h300; d_we = 1'b0;
      if_req = 1'b1; d_req = 1'b1;
      ng = 0; sc = 0; guard = 0; prev_req = mem_req;
      while (ng < 10 && guard < 200) begin
         tick();
         guard++;
         if (mem_req && !prev_req) begin
            exp_if = (sc == LIM);
            sc = exp_if ? 0 : sc + 1;
            chk($sformatf("order_grant%0d", ng), mem_addr,
                exp_if ? 32'h40 : 32'h300);
            ng++;
         end
         prev_req = mem_req;
      end
      chk("order_count", 32'(ng), 32'd10);
      if_req = 1'b0; d_req = 1'b0;
      repeat (4) tick();

      // flush during a slow fetch
      ack_delay = 3;
      if_req = 1'b1; if_addr = 32'h40;
      tick();
      chk("fl_mem_req", 32'(mem_req), 32'd1);
      chk("fl_addr",    mem_addr,     32'h40);
      tick();
      if_flush = 1'b1; if_req = 1'b0;
      tick();
      if_flush = 1'b0;
      seen = 0;
      repeat (6) begin
         tick();
         if (if_valid) seen++;
      end
      chk("fl_no_ifvalid", 32'(seen),    32'd0);
      chk("fl_idle",       32'(mem_req), 32'd0);
      ack_delay = 0;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h104;
      tick();
      chk("fl_regrant", 32'(mem_req), 32'd1);
      tick();
      chk("fl_ld_valid", 32'(d_valid), 32'd1);
      chk("fl_ld_rdata", d_rdata,      dflt(32'h104));
      d_req = 1'b0;
      tick();

      // flush together with an idle fetch request
      if_req = 1'b1; if_flush = 1'b1; if_addr = 32'h44;
      tick();
      chk("fl_idle_nogrant", 32'(mem_req), 32'd0);
      if_req = 1'b0; if_flush = 1'b0;
      tick();

      // flush in the ack cycle
      ack_delay = 1;
      if_req = 1'b1; if_addr = 32'h48;
      tick();
      tick();
      chk("flack_busy", 32'(mem_req), 32'd1);
      if_flush = 1'b1; if_req = 1'b0;
      tick();
      chk("flack_no_ifvalid", 32'(if_valid), 32'd0);
      chk("flack_idle",       32'(mem_req),  32'd0);
      if_flush = 1'b0;
      tick();
      chk("flack_no_ifvalid2", 32'(if_valid), 32'd0);

      // store held stable until ack
      ack_delay = 2;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'h12345678;
      guard = 0;
      while (d_valid !== 1'b1 && guard < 10) begin
         tick();
         guard++;
         if (mem_req) begin
            chk("st_we",    32'(mem_we), 32'd1);
            chk("st_addr",  mem_addr,    32'h200);
            chk("st_wdata", mem_wdata,   32'h12345678);
         end
      end
      chk("st_done", 32'(d_valid), 32'd1);
      chk("st_rdata_kept", d_rdata, dflt(32'h104));
      d_req = 1'b0; d_we = 1'b0;
      nv = d_valid ? 1 : 0;
      repeat (3) begin
         tick();
         if (d_valid) nv++;
      end
      chk("st_one_pulse", 32'(nv), 32'd1);
      chk("st_mem_written",
          mem_arr.exists(32'h200) ? mem_arr[32'h200] : 32'd0, 32'h12345678);

      // reset while a load is outstanding
      mem_auto = 1'b0;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
      tick();
      chk("rb_busy", 32'(mem_req), 32'd1);
      tick();
      #2 rst_n = 1'b0;
      #1;
      chk("rb_mem_req", 32'(mem_req), 32'd0);
      chk("rb_addr",    mem_addr,     32'd0);
      chk("rb_rdata",   d_rdata,      32'd0);
      d_req = 1'b0;
      #2 rst_n = 1'b1;
      tick();
      mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
      nv = 0;
      repeat (3) begin
         tick();
         if (d_valid || if_valid) nv++;
      end
      chk("rb_stray_ack", 32'(nv), 32'd0);
      mem_auto = 1'b1;

      // random traffic
      rand_delay = 1'b1;
      exp_drd = '0; exp_ird = '0;
      for (int c = 0; c < 3000; c++) begin
         tick();
         chk("rnd_excl", 32'(if_valid & d_valid), 32'd0);
         if (d_valid) begin
            chk("rnd_d_owner", 32'(d_pend), 32'd1);
            if (d_pend && !d_we)
               exp_drd = gold.exists(d_addr) ? gold[d_addr] : dflt(d_addr);
            if (d_pend && d_we)
               gold[d_addr] = d_wdata;
            d_pend = 1'b0; d_req = 1'b0; d_age = 0;
         end
         chk("rnd_d_rdata", d_rdata, exp_drd);
         if (if_valid) begin
            chk("rnd_if_owner", 32'(if_pend), 32'd1);
            if (if_pend) exp_ird = dflt(if_addr);
            if_pend = 1'b0; if_req = 1'b0; if_age = 0;
         end
         chk("rnd_if_rdata", if_rdata, exp_ird);
         if (d_pend) d_age++;
         if (if_pend) if_age++;
         if (d_age > 40) begin
            chk("rnd_d_hang", 32'(d_age), 32'd40);
            d_pend = 1'b0; d_req = 1'b0; d_age = 0;
         end
         if (if_age > 60) begin
            chk("rnd_if_hang", 32'(if_age), 32'd60);
            if_pend = 1'b0; if_req = 1'b0; if_age = 0;
         end
         if_flush = 1'b0;
         if (if_pend && $urandom_range(0, 15) == 0) begin
            if_flush = 1'b1; if_pend = 1'b0; if_req = 1'b0; if_age = 0;
         end
         if (!d_pend && $urandom_range(0, 2) == 0) begin
            d_pend  = 1'b1;
            d_req   = 1'b1;
            d_we    = ($urandom_range(0, 2) == 0);
            d_addr  = 32'h1000 + 32'($urandom_range(0, 15) << 2);
            d_wdata = $urandom;
         end
         if (!if_pend && !if_flush && $urandom_range(0, 2) == 0) begin
            if_pend = 1'b1;
            if_req  = 1'b1;
            if_addr = 32'($urandom_range(0, 63) << 2);
         end
      end
      if_req = 1'b0; d_req = 1'b0; if_flush = 1'b0;
      repeat (8) tick();

      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule
